// File: rtl/hazard_control_unit.sv
// Central stall/flush controller for the 5-stage pipeline: combinational hold/bubble
// outputs from the current state and hazards, plus a redirect tracker and perf counters.
module hazard_control_unit #(
    parameter int CNT_W   = 32,
    parameter int FLUSH_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               imem_busywait,
    input  logic               dmem_busywait,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               ex_memRead,
    input  logic               ex_writeEnable,
    input  logic [4:0]         ex_des_register,
    input  logic               ex_Insthit,
    input  logic               branch_taken,
    output logic               pc_hold,
    output logic               stall_1,
    output logic               stall_2,
    output logic               stall_3,
    output logic               flush_1,
    output logic               flush_2,
    output logic               flush_4,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [FLUSH_W-1:0] flush_count,
    output logic [1:0]         state_out
);

    localparam logic [1:0] RUN           = 2'd0;
    localparam logic [1:0] MEM_WAIT      = 2'd1;
    localparam logic [1:0] LOAD_BUBBLE   = 2'd2;
    localparam logic [1:0] REDIRECT_WAIT = 2'd3;

    logic [1:0] state, next_state;
    logic       lu, br, count_flush;

    assign lu = ex_Insthit && ex_memRead && ex_writeEnable && (ex_des_register != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_des_register)) ||
                 (id_uses_rs2 && (id_rs2 == ex_des_register)));
    assign br = branch_taken && ex_Insthit;
    assign state_out = state;

    always_comb begin
        pc_hold     = 1'b0;
        stall_1     = 1'b0;
        stall_2     = 1'b0;
        stall_3     = 1'b0;
        flush_1     = 1'b0;
        flush_2     = 1'b0;
        flush_4     = 1'b0;
        count_flush = 1'b0;
        next_state  = RUN;
        if (reset) begin
            flush_1 = 1'b1;
            flush_2 = 1'b1;
            flush_4 = 1'b1;
        end else if (dmem_busywait) begin
            // Freeze everything up to MEM; a pending redirect survives the freeze.
            pc_hold    = 1'b1;
            stall_1    = 1'b1;
            stall_2    = 1'b1;
            stall_3    = 1'b1;
            flush_4    = 1'b1;
            next_state = (state == REDIRECT_WAIT) ? REDIRECT_WAIT : MEM_WAIT;
        end else if (state == REDIRECT_WAIT) begin
            // Whatever arrives from the fetch started before the redirect is wrong-path.
            flush_1    = 1'b1;
            pc_hold    = imem_busywait;
            next_state = imem_busywait ? REDIRECT_WAIT : RUN;
        end else if (br) begin
            flush_1     = 1'b1;
            flush_2     = 1'b1;
            count_flush = 1'b1;
            next_state  = imem_busywait ? REDIRECT_WAIT : RUN;
        end else if (lu && (state != LOAD_BUBBLE)) begin
            pc_hold    = 1'b1;
            stall_1    = 1'b1;
            flush_2    = 1'b1;
            next_state = LOAD_BUBBLE;
        end else if (imem_busywait) begin
            pc_hold = 1'b1;
            flush_1 = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= next_state;
            if (pc_hold)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (count_flush && (flush_count != '1))
                flush_count <= flush_count + FLUSH_W'(1);
        end
    end

endmodule
